shadowmask_loader: RTL



---
 rtl/shadowmask_loader.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/shadowmask_loader.sv
// Command-side writer for the shadowmask post-processor: mirrors live OSD mask
// settings and streams a downloaded pattern file into the size registers and LUT.
module shadowmask_loader #(
    parameter int CMD_GAP = 0,
    parameter int TIMEOUT = 65535
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        mask_enable,
    input  logic        mask_2x,
    input  logic        mask_rotate,
    input  logic        load_start,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        cmd_wr,
    output logic [15:0] cmd_out,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int GW = (CMD_GAP > 0) ? $clog2(CMD_GAP + 1) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BLANK,
        S_HDR,
        S_SEND_V,
        S_SEND_H,
        S_LUT,
        S_RESTORE
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [5:0]    addr_q, addr_d;
    logic [2:0]    vmax_q, vmax_d;
    logic [2:0]    hmax_q, hmax_d;
    logic          err_q, err_d;
    logic          pending_q, pending_d;
    logic [2:0]    prev_q;

    logic          cmd_wr_q, cmd_wr_d;
    logic [15:0]   cmd_out_q, cmd_out_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic [2:0]    live;
    logic          changed;
    logic          slot;
    logic          accept;
    logic          hdr_ok;
    logic          tmo_hit;
    logic [5:0]    last_addr;
    logic          unused_hdr_bits;

    assign live      = {mask_rotate, mask_2x, mask_enable};
    assign changed   = (live != prev_q);
    assign slot      = (gap_q == '0);
    assign accept    = in_valid && in_ready_q;
    assign hdr_ok    = (in_data[15:12] == 4'h1) && !in_data[7] && !in_data[3];
    assign tmo_hit   = (tmo_q == TW'(TIMEOUT - 1));
    assign last_addr = {vmax_q, 3'b111};

    // Header bits [11:8] carry nothing this block cares about.
    assign unused_hdr_bits = ^in_data[11:8];

    always_comb begin
        state_d   = state_q;
        cmd_wr_d  = 1'b0;
        cmd_out_d = 16'h0000;
        done_d    = 1'b0;
        error_d   = 1'b0;
        pending_d = pending_q | changed;
        tmo_d     = tmo_q;
        addr_d    = addr_q;
        vmax_d    = vmax_q;
        hmax_d    = hmax_q;
        err_d     = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d = S_BLANK;
                    err_d   = 1'b0;
                    addr_d  = 6'd0;
                end else if (pending_q && slot) begin
                    cmd_wr_d  = 1'b1;
                    cmd_out_d = {13'd0, live};
                    pending_d = changed;
                end
            end
            S_BLANK: begin
                if (slot) begin
                    cmd_wr_d  = 1'b1;
                    cmd_out_d = {13'd0, live[2:1], 1'b0};
                    state_d   = S_HDR;
                    tmo_d     = '0;
                end
            end
            S_HDR: begin
                if (accept) begin
                    tmo_d = '0;
                    if (hdr_ok) begin
                        vmax_d  = in_data[6:4];
                        hmax_d  = in_data[2:0];
                        state_d = S_SEND_V;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_RESTORE;
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_RESTORE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_SEND_V: begin
                if (slot) begin
                    cmd_wr_d  = 1'b1;
                    cmd_out_d = {3'b001, 10'd0, vmax_q};
                    state_d   = S_SEND_H;
                end
            end
            S_SEND_H: begin
                if (slot) begin
                    cmd_wr_d  = 1'b1;
                    cmd_out_d = {3'b010, 10'd0, hmax_q};
                    state_d   = S_LUT;
                end
            end
            S_LUT: begin
                // in_ready only rises with the gap elapsed, so an accepted word
                // can always issue its write on the next edge.
                if (accept) begin
                    cmd_wr_d  = 1'b1;
                    cmd_out_d = {3'b011, 3'b000, addr_q, 1'b0, in_data[2:0]};
                    tmo_d     = '0;
                    addr_d    = addr_q + 6'd1;
                    if (addr_q == last_addr) begin
                        state_d = S_RESTORE;
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_RESTORE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_RESTORE: begin
                if (slot) begin
                    cmd_wr_d  = 1'b1;
                    cmd_out_d = {13'd0, live};
                    done_d    = !err_q;
                    error_d   = err_q;
                    err_d     = 1'b0;
                    pending_d = changed;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        gap_d = gap_q;
        if (cmd_wr_d) begin
            gap_d = GW'(CMD_GAP);
        end else if (!slot) begin
            gap_d = gap_q - GW'(1);
        end
    end

    // Readiness requires the gap to have fully drained in the current cycle,
    // so in_ready stays low for every gap cycle after a command.
    always_comb begin
        in_ready_d = ((state_d == S_HDR) || (state_d == S_LUT)) && !cmd_wr_d && slot;
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= S_IDLE;
            gap_q      <= '0;
            tmo_q      <= '0;
            addr_q     <= 6'd0;
            vmax_q     <= 3'd0;
            hmax_q     <= 3'd0;
            err_q      <= 1'b0;
            pending_q  <= 1'b1;
            prev_q     <= live;
            cmd_wr_q   <= 1'b0;
            cmd_out_q  <= 16'h0000;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            tmo_q      <= tmo_d;
            addr_q     <= addr_d;
            vmax_q     <= vmax_d;
            hmax_q     <= hmax_d;
            err_q      <= err_d;
            pending_q  <= pending_d;
            prev_q     <= live;
            cmd_wr_q   <= cmd_wr_d;
            cmd_out_q  <= cmd_out_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign cmd_wr   = cmd_wr_q;
    assign cmd_out  = cmd_out_q;
    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule
